// File: rtl/chess_pkg.sv
// Shared chess encodings for the move generators: piece codes, the board
// square word, ray directions with their (row, col) steps, and ray masks.
package chess_pkg;

    typedef enum logic [2:0] {
        PIECE_NONE   = 3'b000,
        PIECE_PAWN   = 3'b001,
        PIECE_KNIGHT = 3'b010,
        PIECE_BISHOP = 3'b011,
        PIECE_ROOK   = 3'b100,
        PIECE_QUEEN  = 3'b101,
        PIECE_KING   = 3'b110
    } piece_t;

    typedef struct packed {
        logic [2:0] kind;
        logic       color;
        logic       occupied;
    } square_t;

    typedef enum logic [2:0] {
        DIR_UP,
        DIR_UP_RIGHT,
        DIR_RIGHT,
        DIR_DOWN_RIGHT,
        DIR_DOWN,
        DIR_DOWN_LEFT,
        DIR_LEFT,
        DIR_UP_LEFT
    } dir_t;

    // Two's-complement step per direction: 2'b11 = -1, 2'b01 = +1.
    localparam logic [1:0] DIR_DROW [8] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11};
    localparam logic [1:0] DIR_DCOL [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};

    localparam logic [7:0] BISHOP_MASK = 8'hAA;
    localparam logic [7:0] ROOK_MASK   = 8'h55;
    localparam logic [7:0] QUEEN_MASK  = 8'hFF;

    // Non-sliding or unknown pieces get an empty mask, which marks them invalid.
    function automatic logic [7:0] ray_mask(input logic [2:0] kind);
        case (piece_t'(kind))
            PIECE_BISHOP: ray_mask = BISHOP_MASK;
            PIECE_ROOK:   ray_mask = ROOK_MASK;
            PIECE_QUEEN:  ray_mask = QUEEN_MASK;
            default:      ray_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/slider_ray_scanner_ray_step.sv
// One step along a ray: adds the direction delta to a board square and
// flags when the result leaves the 8x8 board (carry or borrow out of 3 bits).
module ray_step
    import chess_pkg::*;
(
    input  logic [2:0] cur_row,
    input  logic [2:0] cur_col,
    input  dir_t       dir,
    output logic [2:0] next_row,
    output logic [2:0] next_col,
    output logic       off_board
);

    logic [3:0] sum_row;
    logic [3:0] sum_col;

    always_comb begin
        sum_row = {1'b0, cur_row} + {{2{DIR_DROW[dir][1]}}, DIR_DROW[dir]};
        sum_col = {1'b0, cur_col} + {{2{DIR_DCOL[dir][1]}}, DIR_DCOL[dir]};
    end

    assign next_row  = sum_row[2:0];
    assign next_col  = sum_col[2:0];
    assign off_board = sum_row[3] | sum_col[3];

endmodule

// File: rtl/slider_ray_scanner.sv
// Walks every ray of a bishop, rook or queen through one board-RAM read port
// and reports the reachable square count and capture flag per ray.
module slider_ray_scanner
    import chess_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  row,
    input  logic [2:0]  column,
    input  logic        color,
    input  logic [2:0]  piece_type,
    output logic        rd_en,
    output logic [2:0]  rd_row,
    output logic [2:0]  rd_col,
    input  logic [4:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] allow,
    output logic [7:0]  capture
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DIR   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    logic [2:0] state;
    logic [2:0] piece_row;
    logic [2:0] piece_col;
    logic [2:0] piece_kind;
    logic       piece_color;
    logic [7:0] mask;
    logic [3:0] ptr;
    dir_t       cur_dir;
    logic [2:0] cur_row;
    logic [2:0] cur_col;
    logic [2:0] count;
    logic [1:0] wait_cnt;
    logic [2:0] held_row;
    logic [2:0] held_col;
    logic       ray_found;
    logic [2:0] ray_sel;
    logic [2:0] step_row;
    logic [2:0] step_col;
    logic       step_off;
    square_t    square;
    logic [2:0] unused_kind;

    assign square      = square_t'(rd_data);
    assign unused_kind = square.kind;
    assign mask        = ray_mask(piece_kind);

    // Lowest masked ray at or above the pointer; scanning downward lets the last hit win.
    always_comb begin
        ray_found = 1'b0;
        ray_sel   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= ptr)) begin
                ray_found = 1'b1;
                ray_sel   = 3'(i);
            end
        end
    end

    ray_step u_step (
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .dir       (cur_dir),
        .next_row  (step_row),
        .next_col  (step_col),
        .off_board (step_off)
    );

    // The read address is live during ISSUE and otherwise replays the last one issued.
    assign rd_en  = (state == S_ISSUE) && !step_off;
    assign rd_row = rd_en ? step_row : held_row;
    assign rd_col = rd_en ? step_col : held_col;
    assign busy   = (state != S_IDLE) && (state != S_FIN);
    assign done   = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            piece_row   <= 3'd0;
            piece_col   <= 3'd0;
            piece_kind  <= 3'd0;
            piece_color <= 1'b0;
            ptr         <= 4'd0;
            cur_dir     <= DIR_UP;
            cur_row     <= 3'd0;
            cur_col     <= 3'd0;
            count       <= 3'd0;
            wait_cnt    <= 2'd0;
            held_row    <= 3'd0;
            held_col    <= 3'd0;
            err         <= 1'b0;
            allow       <= 24'd0;
            capture     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        piece_row   <= row;
                        piece_col   <= column;
                        piece_color <= color;
                        piece_kind  <= piece_type;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    allow   <= 24'd0;
                    capture <= 8'd0;
                    ptr     <= 4'd0;
                    err     <= (mask == 8'h00);
                    state   <= (mask == 8'h00) ? S_FIN : S_DIR;
                end
                S_DIR: begin
                    if (ray_found) begin
                        cur_dir <= dir_t'(ray_sel);
                        cur_row <= piece_row;
                        cur_col <= piece_col;
                        count   <= 3'd0;
                        state   <= S_ISSUE;
                    end else begin
                        state <= S_FIN;
                    end
                end
                S_ISSUE: begin
                    if (step_off) begin
                        allow[3*int'(cur_dir) +: 3] <= count;
                        ptr   <= {1'b0, cur_dir} + 4'd1;
                        state <= S_DIR;
                    end else begin
                        held_row <= step_row;
                        held_col <= step_col;
                        wait_cnt <= WAIT_INIT;
                        state    <= (READ_LAT > 1) ? S_WAIT : S_CHECK;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_CHECK: begin
                    if (!square.occupied) begin
                        count   <= count + 3'd1;
                        cur_row <= step_row;
                        cur_col <= step_col;
                        state   <= S_ISSUE;
                    end else if (square.color == piece_color) begin
                        allow[3*int'(cur_dir) +: 3] <= count;
                        ptr   <= {1'b0, cur_dir} + 4'd1;
                        state <= S_DIR;
                    end else begin
                        allow[3*int'(cur_dir) +: 3] <= count + 3'd1;
                        capture[cur_dir] <= 1'b1;
                        ptr   <= {1'b0, cur_dir} + 4'd1;
                        state <= S_DIR;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slider_ray_scanner.sv
// Scoreboard bench: drives a READ_LAT=1 and a READ_LAT=3 scanner side by side
// from one stimulus stream, each with its own board-RAM pipeline model.
module tb_slider_ray_scanner;

    typedef struct {
        int          id;
        logic [23:0] allow;
        logic [7:0]  capture;
        logic        err;
        int          reads;
        int          lat1;
        int          lat3;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic             start;
    logic [2:0]       row;
    logic [2:0]       column;
    logic             color;
    logic [2:0]       piece_type;
    logic [1:0]       rd_en_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0]       err_v;
    logic [1:0][2:0]  rd_row_v;
    logic [1:0][2:0]  rd_col_v;
    logic [1:0][4:0]  rd_data_v;
    logic [1:0][23:0] allow_v;
    logic [1:0][7:0]  capture_v;
    logic [4:0]       board [64];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e;
    bit   idle_req = 1'b0;
    bit   timeout_req = 1'b0;
    bit   final_req = 1'b0;
    int   start_cyc [2];
    int   reads [2];
    int   last_rd [2];
    int   busy_gap [2];
    bit   active [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [4:0]     pipe [LAT];
        logic [LAT-1:0] vpipe;

        // Data is only meaningful exactly LAT cycles after rd_en; any other cycle sees a white piece.
        always @(posedge clk) begin
            if (!reset_n) begin
                vpipe <= '0;
            end else begin
                vpipe[0] <= rd_en_v[k];
                for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
            end
            pipe[0] <= board[{rd_row_v[k], rd_col_v[k]}];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        assign rd_data_v[k] = vpipe[LAT-1] ? pipe[LAT-1] : 5'b00001;

        slider_ray_scanner #(.READ_LAT(LAT)) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start),
            .row        (row),
            .column     (column),
            .color      (color),
            .piece_type (piece_type),
            .rd_en      (rd_en_v[k]),
            .rd_row     (rd_row_v[k]),
            .rd_col     (rd_col_v[k]),
            .rd_data    (rd_data_v[k]),
            .busy       (busy_v[k]),
            .done       (done_v[k]),
            .err        (err_v[k]),
            .allow      (allow_v[k]),
            .capture    (capture_v[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [23:0] pack_allow(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic exp_t mk(input int id, input logic [23:0] a, input logic [7:0] cap,
                                input logic er, input int rd, input int l1, input int l3);
        exp_t x;
        x.id = id; x.allow = a; x.capture = cap; x.err = er; x.reads = rd; x.lat1 = l1; x.lat3 = l3;
        return x;
    endfunction

    task automatic checkOutput(input string name, input int k, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s (READ_LAT=%0d): got 0x%0h, expected 0x%0h", name, lat_of(k), actual, expected);
        end
    endtask

    // Monitor: the only process that compares; it pops an expectation on every done pulse.
    always @(negedge clk) begin
        cyc++;
        if (idle_req) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput("idle_rd_en",   k, 32'(rd_en_v[k]),   32'd0);
                checkOutput("idle_rd_addr", k, 32'({rd_row_v[k], rd_col_v[k]}), 32'd0);
                checkOutput("idle_busy",    k, 32'(busy_v[k]),    32'd0);
                checkOutput("idle_done",    k, 32'(done_v[k]),    32'd0);
                checkOutput("idle_err",     k, 32'(err_v[k]),     32'd0);
                checkOutput("idle_allow",   k, 32'(allow_v[k]),   32'd0);
                checkOutput("idle_capture", k, 32'(capture_v[k]), 32'd0);
            end
        end
        if (timeout_req) checkOutput("done_timeout", 0, 32'd1, 32'd0);
        if (final_req) begin
            checkOutput("leftover_expect", 0, 32'(q0.size()), 32'd0);
            checkOutput("leftover_expect", 1, 32'(q1.size()), 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                active[k] = 1'b0;
            end else begin
                if (start && !busy_v[k] && !done_v[k]) begin
                    active[k]    = 1'b1;
                    start_cyc[k] = cyc;
                    reads[k]     = 0;
                    last_rd[k]   = -100;
                    busy_gap[k]  = 0;
                end else if (active[k] && !done_v[k] && !busy_v[k]) begin
                    busy_gap[k]++;
                end
                if (rd_en_v[k]) begin
                    checkOutput("read_spacing", k, 32'((cyc - last_rd[k]) > lat_of(k)), 32'd1);
                    reads[k]++;
                    last_rd[k] = cyc;
                end
                if (done_v[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        checkOutput("unexpected_done", k, 32'd1, 32'd0);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        $display("[TB] scan %0d done on READ_LAT=%0d", e.id, lat_of(k));
                        checkOutput("allow",    k, 32'(allow_v[k]),   32'(e.allow));
                        checkOutput("capture",  k, 32'(capture_v[k]), 32'(e.capture));
                        checkOutput("err",      k, 32'(err_v[k]),     32'(e.err));
                        checkOutput("reads",    k, 32'(reads[k]),     32'(e.reads));
                        checkOutput("latency",  k, 32'(cyc - start_cyc[k]), 32'((k == 0) ? e.lat1 : e.lat3));
                        checkOutput("busy_gap", k, 32'(busy_gap[k]),  32'd0);
                        checkOutput("busy_at_done", k, 32'(busy_v[k]), 32'd0);
                    end
                    active[k] = 1'b0;
                end
            end
        end
    end

    task automatic clearBoard();
        for (int i = 0; i < 64; i++) board[i] = 5'b00000;
    endtask

    task automatic requestIdleCheck();
        idle_req = 1'b1;
        @(negedge clk);
        #1 idle_req = 1'b0;
    endtask

    task automatic pulseStart(input logic [2:0] r, input logic [2:0] c, input logic col, input logic [2:0] kind);
        @(posedge clk);
        #1;
        row = r; column = c; color = col; piece_type = kind; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        row = 3'($urandom); column = 3'($urandom); color = 1'($urandom); piece_type = 3'($urandom);
    endtask

    task automatic waitDone();
        bit got0 = 1'b0;
        bit got1 = 1'b0;
        for (int n = 0; n < 400 && !(got0 && got1); n++) begin
            @(negedge clk);
            if (done_v[0]) got0 = 1'b1;
            if (done_v[1]) got1 = 1'b1;
        end
        if (!(got0 && got1)) begin
            timeout_req = 1'b1;
            @(negedge clk);
            #1 timeout_req = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] c, input logic col,
                                 input logic [2:0] kind, input exp_t x);
        q0.push_back(x);
        q1.push_back(x);
        pulseStart(r, c, col, kind);
        waitDone();
    endtask

    task automatic setupRookBoard();
        clearBoard();
        board[{3'd0, 3'd3}] = 5'b00101;
        board[{3'd2, 3'd0}] = 5'b00111;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; row = '0; column = '0; color = 1'b0; piece_type = '0;
        clearBoard();
        repeat (3) @(posedge clk);
        #1;
        requestIdleCheck();
        reset_n = 1'b1;

        // Latency = LOAD + each ray's DIR + reads*(LAT+1) + edge ISSUEs + closing DIR + FIN.
        applyStimulus(3'd7, 3'd0, 1'b0, 3'b011, mk(1, pack_allow(0, 7, 0, 0, 0, 0, 0, 0), 8'h00, 1'b0, 7, 25, 39));

        setupRookBoard();
        applyStimulus(3'd0, 3'd0, 1'b1, 3'b100, mk(2, pack_allow(0, 0, 3, 0, 1, 0, 0, 0), 8'h04, 1'b0, 5, 19, 29));

        clearBoard();
        applyStimulus(3'd3, 3'd3, 1'b0, 3'b101, mk(3, pack_allow(3, 3, 4, 4, 4, 3, 3, 3), 8'h00, 1'b0, 27, 73, 127));

        applyStimulus(3'd4, 3'd4, 1'b0, 3'b010, mk(4, 24'd0, 8'h00, 1'b1, 0, 2, 2));
        applyStimulus(3'd1, 3'd6, 1'b1, 3'b110, mk(5, 24'd0, 8'h00, 1'b1, 0, 2, 2));

        q0.push_back(mk(6, pack_allow(3, 3, 4, 4, 4, 3, 3, 3), 8'h00, 1'b0, 27, 73, 127));
        q1.push_back(mk(6, pack_allow(3, 3, 4, 4, 4, 3, 3, 3), 8'h00, 1'b0, 27, 73, 127));
        pulseStart(3'd3, 3'd3, 1'b0, 3'b101);
        repeat (8) @(posedge clk);
        pulseStart(3'd0, 3'd0, 1'b1, 3'b011);
        waitDone();

        pulseStart(3'd3, 3'd3, 1'b0, 3'b101);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        requestIdleCheck();

        setupRookBoard();
        applyStimulus(3'd0, 3'd0, 1'b1, 3'b100, mk(7, pack_allow(0, 0, 3, 0, 1, 0, 0, 0), 8'h04, 1'b0, 5, 19, 29));

        @(posedge clk);
        #1 final_req = 1'b1;
        @(negedge clk);
        #1 final_req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
